layer_scheduler: RTL and testbench

//  Sequences layered LDPC decoding: steps through every layer of the base matrix each iteration and

---
 rtl/layer_scheduler.sv | 172 +++++++++++++++++
 tb/tb_layer_scheduler.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_scheduler.sv
// layer_scheduler: layered LDPC decode sequencer.
// It holds a programmable layer table of {col, shift, slot_en} per [layer][slot].
// Each iteration it walks layers 0..num_layers-1. For every layer it issues one
// descriptor with a valid/ready handshake, then waits for the datapath's
// writeback pulse before moving on.
// Optional feature: define EARLY_TERM_EN to add syndrome_ok/converged. A good
// syndrome seen at an iteration boundary then ends the decode early.
module layer_scheduler #(
  parameter  int Z  = 4,
  parameter  int DC = 6,
  parameter  int NB = 52,
  parameter  int MB = 42,
  parameter  int IW = 4,
  localparam int LW = $clog2(MB + 1),
  localparam int SW = $clog2(DC),
  localparam int CW = $clog2(NB),
  localparam int HW = $clog2(Z)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [LW-1:0]          cfg_layer,
  input  logic [SW-1:0]          cfg_slot,
  input  logic [CW-1:0]          cfg_col,
  input  logic [HW-1:0]          cfg_shift,
  input  logic                   cfg_slot_en,
  input  logic [LW-1:0]          num_layers,
  input  logic [IW-1:0]          max_iter,
  input  logic                   start,
  output logic [DC-1:0][CW-1:0]  col_indices,
  output logic [DC-1:0][HW-1:0]  shift_values,
  output logic [DC-1:0]          slot_valid,
  output logic                   layer_valid,
  input  logic                   layer_ready,
  input  logic                   wb_done,
  output logic [LW-1:0]          layer_idx,
  output logic [IW-1:0]          iter_idx,
  output logic                   busy,
`ifdef EARLY_TERM_EN
  input  logic                   syndrome_ok,
  output logic                   converged,
`endif
  output logic                   done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_WB,
    S_CHECK,
    S_FIN
  } state_t;

  state_t state;

  // Layer table. It is deliberately left out of reset so that a programmed
  // table survives an aborted decode.
  logic [CW-1:0] tbl_col   [MB][DC];
  logic [HW-1:0] tbl_shift [MB][DC];
  logic          tbl_en    [MB][DC];

  // Last layer / last iteration indices, latched at start after clamping.
  logic [LW-1:0] last_layer;
  logic [IW-1:0] last_iter;

  logic tbl_wr;
  assign tbl_wr = cfg_we && (state == S_IDLE) &&
                  (cfg_layer < LW'(MB)) && (cfg_slot < SW'(DC));

  // Table write port: only while idle, so a running decode never sees a row change.
  always_ff @(posedge clk) begin
    if (tbl_wr) begin
      tbl_col[cfg_layer][cfg_slot]   <= cfg_col;
      tbl_shift[cfg_layer][cfg_slot] <= cfg_shift;
      tbl_en[cfg_layer][cfg_slot]    <= cfg_slot_en;
    end
  end

  // Sequencing FSM with registered descriptor and status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      layer_valid  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      layer_idx    <= '0;
      iter_idx     <= '0;
      col_indices  <= '0;
      shift_values <= '0;
      slot_valid   <= '0;
      last_layer   <= '0;
      last_iter    <= '0;
`ifdef EARLY_TERM_EN
      converged    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            layer_idx <= '0;
            iter_idx  <= '0;
            // A zero iteration limit still runs one full pass.
            last_iter <= (max_iter == '0) ? '0 : max_iter - 1'b1;
`ifdef EARLY_TERM_EN
            converged <= 1'b0;
`endif
            if (num_layers == '0) begin
              state <= S_FIN;
            end else begin
              last_layer <= (num_layers > LW'(MB)) ? LW'(MB - 1) : num_layers - 1'b1;
              state      <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          if (!layer_valid) begin
            // Row fetch: the descriptor is registered here and then held
            // steady until the datapath takes it.
            for (int s = 0; s < DC; s++) begin
              col_indices[s]  <= tbl_col[layer_idx][s];
              shift_values[s] <= tbl_shift[layer_idx][s];
              slot_valid[s]   <= tbl_en[layer_idx][s];
            end
            layer_valid <= 1'b1;
          end else if (layer_ready) begin
            layer_valid <= 1'b0;
            state       <= S_WAIT_WB;
          end
        end

        S_WAIT_WB: begin
          if (wb_done) begin
            if (layer_idx == last_layer) begin
              state <= S_CHECK;
            end else begin
              layer_idx <= layer_idx + 1'b1;
              state     <= S_ISSUE;
            end
          end
        end

        S_CHECK: begin
`ifdef EARLY_TERM_EN
          if (syndrome_ok) begin
            converged <= 1'b1;
            state     <= S_FIN;
          end else
`endif
          if (iter_idx == last_iter) begin
            state <= S_FIN;
          end else begin
            iter_idx  <= iter_idx + 1'b1;
            layer_idx <= '0;
            state     <= S_ISSUE;
          end
        end

        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_scheduler.sv
// tb_layer_scheduler: randomized bench for layer_scheduler.
// The reference model is transaction level. A decode of L layers and I
// iterations must issue the descriptor sequence (k mod L, k div L) for
// k = 0..L*I-1, with each descriptor taken from a shadow copy of the table.
// The bench emulates the datapath side using random ready and a random
// writeback delay.
module tb_layer_scheduler;
  localparam int Z  = 4;
  localparam int DC = 6;
  localparam int NB = 52;
  localparam int MB = 42;
  localparam int IW = 4;
  localparam int LW = $clog2(MB + 1);
  localparam int SW = $clog2(DC);
  localparam int CW = $clog2(NB);
  localparam int HW = $clog2(Z);

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  cfg_we;
  logic [LW-1:0]         cfg_layer;
  logic [SW-1:0]         cfg_slot;
  logic [CW-1:0]         cfg_col;
  logic [HW-1:0]         cfg_shift;
  logic                  cfg_slot_en;
  logic [LW-1:0]         num_layers;
  logic [IW-1:0]         max_iter;
  logic                  start;
  logic [DC-1:0][CW-1:0] col_indices;
  logic [DC-1:0][HW-1:0] shift_values;
  logic [DC-1:0]         slot_valid;
  logic                  layer_valid;
  logic                  layer_ready;
  logic                  wb_done;
  logic [LW-1:0]         layer_idx;
  logic [IW-1:0]         iter_idx;
  logic                  busy;
  logic                  done;
`ifdef EARLY_TERM_EN
  logic                  syndrome_ok;
  logic                  converged;
`endif

  layer_scheduler #(.Z(Z), .DC(DC), .NB(NB), .MB(MB), .IW(IW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_we       (cfg_we),
    .cfg_layer    (cfg_layer),
    .cfg_slot     (cfg_slot),
    .cfg_col      (cfg_col),
    .cfg_shift    (cfg_shift),
    .cfg_slot_en  (cfg_slot_en),
    .num_layers   (num_layers),
    .max_iter     (max_iter),
    .start        (start),
    .col_indices  (col_indices),
    .shift_values (shift_values),
    .slot_valid   (slot_valid),
    .layer_valid  (layer_valid),
    .layer_ready  (layer_ready),
    .wb_done      (wb_done),
    .layer_idx    (layer_idx),
    .iter_idx     (iter_idx),
    .busy         (busy),
`ifdef EARLY_TERM_EN
    .syndrome_ok  (syndrome_ok),
    .converged    (converged),
`endif
    .done         (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Shadow of the layer table: written only when the DUT is known idle.
  logic [CW-1:0] m_col [MB][DC];
  logic [HW-1:0] m_sh  [MB][DC];
  logic          m_en  [MB][DC];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cfg_write(input int l, input int s, input int c, input int h, input bit e);
    @(negedge clk);
    cfg_we      = 1'b1;
    cfg_layer   = LW'(l);
    cfg_slot    = SW'(s);
    cfg_col     = CW'(c);
    cfg_shift   = HW'(h);
    cfg_slot_en = e;
    if (l < MB && s < DC) begin
      m_col[l][s] = CW'(c);
      m_sh[l][s]  = HW'(h);
      m_en[l][s]  = e;
    end
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid"}, layer_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_layer"}, layer_idx, 0);
    chk({tag, "_iter"}, iter_idx, 0);
    chk({tag, "_col"}, 64'(col_indices), 0);
    chk({tag, "_shift"}, 64'(shift_values), 0);
    chk({tag, "_slotv"}, slot_valid, 0);
  endtask

  // Compare the visible descriptor against shadow row l.
  task automatic chk_desc(input string tag, input int l);
    logic [DC-1:0][CW-1:0] e_col;
    logic [DC-1:0][HW-1:0] e_sh;
    logic [DC-1:0]         e_en;
    for (int s = 0; s < DC; s++) begin
      e_col[s] = m_col[l][s];
      e_sh[s]  = m_sh[l][s];
      e_en[s]  = m_en[l][s];
    end
    chk({tag, "_col"}, 64'(col_indices), 64'(e_col));
    chk({tag, "_shift"}, 64'(shift_values), 64'(e_sh));
    chk({tag, "_slotv"}, slot_valid, e_en);
  endtask

  // One full decode. nl/mi are the raw requested values. rdy_pct is the
  // probability of ready. hold forces ready low for that many cycles on the
  // first descriptor. et is the iteration after which the syndrome is good
  // (-1 means never).
  task automatic run_decode(input int nl, input int mi, input int rdy_pct,
                            input int hold, input int et);
    int nle, mie, iters, total;
    int issued, wbs, pend, cyc, gap, gap_exp, holdc;
    bit outst, finished, stalled;
    logic [DC-1:0][CW-1:0] s_col;
    logic [DC-1:0][HW-1:0] s_sh;
    logic [DC-1:0]         s_en;
    logic [LW-1:0]         s_layer;
    nle   = (nl > MB) ? MB : nl;
    mie   = (mi == 0) ? 1 : mi;
    iters = mie;
`ifdef EARLY_TERM_EN
    if (et >= 0 && et + 1 < mie) iters = et + 1;
`endif
    total = nle * iters;
    issued = 0; wbs = 0; pend = 0; cyc = 0; holdc = 0;
    outst = 0; finished = 0; stalled = 0;
    s_col = '0; s_sh = '0; s_en = '0; s_layer = '0;

    @(negedge clk);
    start      = 1'b1;
    num_layers = LW'(nl);
    max_iter   = IW'(mi);
`ifdef EARLY_TERM_EN
    syndrome_ok = 1'b0;
`endif
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_iter", iter_idx, 0);
    chk("start_layer", layer_idx, 0);

    if (nle == 0) begin
      chk("nl0_done_early", done, 0);
      @(negedge clk);
      chk("nl0_done", done, 1);
      chk("nl0_busy", busy, 0);
      chk("nl0_iter", iter_idx, 0);
      chk("nl0_valid", layer_valid, 0);
`ifdef EARLY_TERM_EN
      chk("nl0_conv", converged, 0);
`endif
      @(negedge clk);
      chk("nl0_done_pulse", done, 0);
      return;
    end

    // The first valid must show up after exactly one idle observation.
    gap = 0;
    gap_exp = 1;
    while (!finished && cyc < 4000) begin
      // Observe outputs.
      if (done) begin
        chk("done_busy", busy, 0);
        chk("issues_at_done", issued, total);
        chk("wbs_at_done", wbs, total);
        finished = 1;
        break;
      end
      chk("busy_held", busy, 1);
      if (layer_valid) begin
        if (gap >= 0) begin
          chk("valid_gap", gap, gap_exp);
          gap = -1;
        end
        if (stalled) begin
          chk("stall_col", 64'(col_indices), 64'(s_col));
          chk("stall_shift", 64'(shift_values), 64'(s_sh));
          chk("stall_slotv", slot_valid, s_en);
          chk("stall_layer", layer_idx, s_layer);
        end
      end else if (gap >= 0) begin
        gap++;
      end

      // Drive the datapath side for the next edge.
      wb_done = 1'b0;
      if (outst) begin
        if (pend == 0) begin
          wb_done = 1'b1;
          outst   = 0;
          wbs++;
          if (wbs == total) begin
            gap = -1;
          end else begin
            gap     = 0;
            gap_exp = (wbs % nle == 0) ? 2 : 1;
          end
        end else begin
          pend--;
        end
      end else begin
        // A writeback pulse with nothing outstanding must be ignored.
        wb_done = ($urandom_range(0, 7) == 0);
      end
`ifdef EARLY_TERM_EN
      syndrome_ok = (et >= 0) && (wbs >= (et + 1) * nle);
`endif
      // Table writes during a decode must be ignored.
      cfg_we      = ($urandom_range(0, 3) == 0);
      cfg_layer   = LW'($urandom_range(0, 3));
      cfg_slot    = SW'($urandom_range(0, DC - 1));
      cfg_col     = CW'($urandom_range(0, NB - 1));
      cfg_shift   = HW'($urandom_range(0, Z - 1));
      cfg_slot_en = 1'($urandom_range(0, 1));

      if (layer_valid && issued == 0 && holdc < hold) begin
        layer_ready = 1'b0;
        holdc++;
      end else begin
        layer_ready = ($urandom_range(0, 99) < rdy_pct);
      end

      if (layer_valid && layer_ready) begin
        chk("no_extra_issue", (issued < total), 1);
        chk("issue_layer", layer_idx, issued % nle);
        chk("issue_iter", iter_idx, issued / nle);
        chk_desc("issue", issued % nle);
        issued++;
        outst   = 1;
        pend    = $urandom_range(0, 4);
        stalled = 0;
      end else if (layer_valid) begin
        stalled = 1;
        s_col   = col_indices;
        s_sh    = shift_values;
        s_en    = slot_valid;
        s_layer = layer_idx;
      end else begin
        stalled = 0;
      end

      @(negedge clk);
      cyc++;
    end
    cfg_we      = 1'b0;
    wb_done     = 1'b0;
    layer_ready = 1'b0;
    chk("decode_timeout", finished, 1);
    chk("issues_total", issued, total);
`ifdef EARLY_TERM_EN
    chk("converged", converged, (et >= 0 && et < mie));
    syndrome_ok = 1'b0;
`endif
    @(negedge clk);
    chk("done_one_pulse", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_layer = '0; cfg_slot = '0; cfg_col = '0;
    cfg_shift = '0; cfg_slot_en = 1'b0; num_layers = '0; max_iter = '0;
    start = 1'b0; layer_ready = 1'b0; wb_done = 1'b0;
`ifdef EARLY_TERM_EN
    syndrome_ok = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk_outputs_zero("reset");
`ifdef EARLY_TERM_EN
    chk("reset_conv", converged, 0);
`endif
    rst = 1'b1;

    // Program every row with random content, then row 1 with a known pattern.
    for (int l = 0; l < MB; l++)
      for (int s = 0; s < DC; s++)
        cfg_write(l, s, $urandom_range(0, NB - 1), $urandom_range(0, Z - 1),
                  1'($urandom_range(0, 1)));
    cfg_write(1, 0, 5, 0, 1);
    cfg_write(1, 1, 17, 1, 1);
    cfg_write(1, 2, 30, 2, 1);
    cfg_write(1, 3, 51, 3, 1);
    cfg_write(1, 4, 9, 1, 0);
    cfg_write(1, 5, 44, 2, 0);
    // This row lies outside the table and must leave the shadowed content intact.
    cfg_write(MB, 0, 7, 1, 1);

    run_decode(3, 2, 100, 0, -1);          // basic three-layer, two-iteration decode
    run_decode(3, 2, 60, 5, -1);           // backpressure on the first descriptor
    run_decode(0, 3, 100, 0, -1);          // empty layer count
    run_decode(2, 0, 100, 0, -1);          // zero iteration limit runs once
    run_decode(50, 1, 80, 0, -1);          // layer count clamped to table depth
    for (int i = 0; i < 4; i++)
      run_decode($urandom_range(1, 6), $urandom_range(0, 3), 70, 0, -1);
`ifdef EARLY_TERM_EN
    run_decode(3, 8, 80, 0, 2);            // good syndrome after iteration 2
    run_decode(2, 2, 80, 0, 5);            // syndrome never good in time
`endif

    // Reset in the middle of a decode: abandon it and emit no done pulse.
    @(negedge clk);
    start = 1'b1; num_layers = 3; max_iter = 2;
    @(negedge clk);
    start = 1'b0; layer_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_busy_before_reset", busy, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_outputs_zero("mid_reset");
    rst = 1'b1;
    layer_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_reset_done", done, 0);
      chk("post_reset_busy", busy, 0);
      chk("post_reset_valid", layer_valid, 0);
    end
    run_decode(3, 1, 90, 0, -1);           // a fresh decode still runs after the abort

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
